// File: rtl/xillybus_loop_fifo.sv
// Per-channel loopback FIFOs with open/close stream FSM, flush on quiesce or close.
// Optional XLB_LOOP_LEVEL_EN adds the fill_level_w output (registered per-channel count).
module xillybus_loop_fifo #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NCH        = 2,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                          bus_clk_w,
    input  logic                          bus_rst_w,
    input  logic                          quiesce_w,
    input  logic [NCH-1:0]                user_w_wren_w,
    input  logic [NCH*DATA_W-1:0]         user_w_data_w,
    input  logic [NCH-1:0]                user_w_open_w,
    output logic [NCH-1:0]                user_w_full_w,
    input  logic [NCH-1:0]                user_r_rden_w,
    output logic [NCH*DATA_W-1:0]         user_r_data_w,
    output logic [NCH-1:0]                user_r_empty_w,
    output logic [NCH-1:0]                user_r_eof_w,
    input  logic [NCH-1:0]                user_r_open_w,
`ifdef XLB_LOOP_LEVEL_EN
    output logic [NCH*(DEPTH_LOG2+1)-1:0] fill_level_w,
`endif
    output logic [NCH-1:0]                ovf_err_w
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_EOF} ch_state_t;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        ch_state_t             state, state_nx;
        logic [DEPTH_LOG2:0]   count;
        logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
        logic [DATA_W-1:0]     mem [DEPTH];
        logic [DATA_W-1:0]     rdata;
        logic                  ovf, flush, full, empty, eof, wr_acc, rd_acc;

        assign flush = quiesce_w || (!user_w_open_w[g] && !user_r_open_w[g]);

        always_ff @(posedge bus_clk_w) begin
            if (bus_rst_w) state <= S_IDLE;
            else           state <= state_nx;
        end

        always_comb begin
            state_nx = state;
            if (flush) begin
                state_nx = S_IDLE;
            end else begin
                case (state)
                    S_IDLE:   if (user_w_open_w[g]) state_nx = S_STREAM;
                    S_STREAM: if (!user_w_open_w[g] && user_r_open_w[g]) state_nx = S_DRAIN;
                    S_DRAIN:  if (count == '0) state_nx = S_EOF;
                    S_EOF:    if (user_w_open_w[g]) state_nx = S_STREAM;
                    default:  state_nx = S_IDLE;
                endcase
            end
        end

        // full/empty come from the registered count only, so a pop never frees room in the same cycle
        always_comb begin
            full   = quiesce_w || (count == FULL_CNT);
            empty  = (count == '0) || !(state == S_STREAM || state == S_DRAIN);
            eof    = (state == S_EOF);
            wr_acc = user_w_wren_w[g] && !full && (state == S_STREAM);
            rd_acc = user_r_rden_w[g] && !empty;
        end

        always_ff @(posedge bus_clk_w) begin
            if (bus_rst_w) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf    <= 1'b0;
                rdata  <= '0;
            end else if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf    <= 1'b0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                    rdata  <= mem[rd_ptr];
                end
                case ({wr_acc, rd_acc})
                    2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
                    2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
                    default: count <= count;
                endcase
                if (user_w_wren_w[g] && count == FULL_CNT) ovf <= 1'b1;
            end
        end

        // storage is deliberately unreset; empty gating keeps stale words unreachable
        always_ff @(posedge bus_clk_w) begin
            if (wr_acc) mem[wr_ptr] <= user_w_data_w[g*DATA_W +: DATA_W];
        end

        assign user_w_full_w[g]                  = full;
        assign user_r_empty_w[g]                 = empty;
        assign user_r_eof_w[g]                   = eof;
        assign ovf_err_w[g]                      = ovf;
        assign user_r_data_w[g*DATA_W +: DATA_W] = rdata;
`ifdef XLB_LOOP_LEVEL_EN
        assign fill_level_w[g*(DEPTH_LOG2+1) +: (DEPTH_LOG2+1)] = count;
`endif
    end

endmodule

// File: tb/tb_xillybus_loop_fifo.sv
// Scoreboard bench for xillybus_loop_fifo with NCH=2, DEPTH_LOG2=4.
module tb_xillybus_loop_fifo;

    logic        clk = 1'b0;
    logic        rst, quiesce;
    logic [1:0]  wren, rden, wopen, ropen;
    logic [63:0] wdata;
    logic [1:0]  full, empty, eof, ovf;
    logic [63:0] rdata;
`ifdef XLB_LOOP_LEVEL_EN
    logic [9:0]  fill_level;
`endif

    always #5 clk = ~clk;

    xillybus_loop_fifo #(.DATA_W(32), .NCH(2), .DEPTH_LOG2(4)) dut (
        .bus_clk_w      (clk),
        .bus_rst_w      (rst),
        .quiesce_w      (quiesce),
        .user_w_wren_w  (wren),
        .user_w_data_w  (wdata),
        .user_w_open_w  (wopen),
        .user_w_full_w  (full),
        .user_r_rden_w  (rden),
        .user_r_data_w  (rdata),
        .user_r_empty_w (empty),
        .user_r_eof_w   (eof),
        .user_r_open_w  (ropen),
`ifdef XLB_LOOP_LEVEL_EN
        .fill_level_w   (fill_level),
`endif
        .ovf_err_w      (ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit [1:0] wr_ok, rd_ok;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of strobes; the model decides acceptance from its pre-edge occupancy.
    task automatic cyc(input logic [1:0] wr, input logic [1:0] rd,
                       input logic [31:0] d0, input logic [31:0] d1);
        bit [1:0] wacc, racc;
        int n0 = q0.size();
        int n1 = q1.size();
        wacc[0] = wr[0] && wr_ok[0] && (n0 < 16);
        wacc[1] = wr[1] && wr_ok[1] && (n1 < 16);
        racc[0] = rd[0] && rd_ok[0] && (n0 > 0);
        racc[1] = rd[1] && rd_ok[1] && (n1 > 0);
        wren  = wr;
        rden  = rd;
        wdata = {d1, d0};
        tick();
        wren = '0;
        rden = '0;
        if (racc[0]) check("rd_ch0", {32'h0, rdata[31:0]},  {32'h0, q0.pop_front()});
        if (racc[1]) check("rd_ch1", {32'h0, rdata[63:32]}, {32'h0, q1.pop_front()});
        if (wacc[0]) q0.push_back(d0);
        if (wacc[1]) q1.push_back(d1);
    endtask

    initial begin
        rst = 1'b1; quiesce = 1'b0; wren = '0; rden = '0;
        wopen = '0; ropen = '0; wdata = '0; wr_ok = '0; rd_ok = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_empty", {62'h0, empty}, 64'h3);
        check("rst_full",  {62'h0, full},  64'h0);
        check("rst_eof",   {62'h0, eof},   64'h0);
        check("rst_ovf",   {62'h0, ovf},   64'h0);
        check("rst_data",  rdata,          64'h0);

        wopen = 2'b11; ropen = 2'b11;
        tick();
        wr_ok = 2'b11; rd_ok = 2'b11;

        // ordered loopback on ch0
        for (int unsigned i = 0; i < 15; i++) cyc(2'b01, 2'b00, 32'h11 + i, 32'h0);
        check("ch0_not_empty", {63'h0, empty[0]}, 64'h0);
        for (int unsigned i = 0; i < 15; i++) cyc(2'b00, 2'b01, 32'h0, 32'h0);
        check("ch0_empty_after", {63'h0, empty[0]}, 64'h1);
        cyc(2'b00, 2'b01, 32'h0, 32'h0);
        check("rd_empty_hold", {32'h0, rdata[31:0]}, 64'h1F);

        // ch1 overflow
        for (int unsigned i = 0; i < 16; i++) cyc(2'b00, 2'b00, 32'h0, 32'h100 + i);
        for (int unsigned i = 0; i < 16; i++) cyc(2'b10, 2'b00, 32'h0, 32'h100 + i);
        check("ch1_full",  {62'h0, full}, 64'h2);
        cyc(2'b10, 2'b00, 32'h0, 32'hDEAD);
        check("ch1_ovf",   {62'h0, ovf},  64'h2);
        check("ch0_empty_iso", {63'h0, empty[0]}, 64'h1);
        for (int unsigned i = 0; i < 16; i++) cyc(2'b00, 2'b10, 32'h0, 32'h0);
        check("ch1_drained", {63'h0, empty[1]}, 64'h1);

        // simultaneous read/write at full and at count 5
        for (int unsigned i = 0; i < 16; i++) cyc(2'b01, 2'b00, 32'h200 + i, 32'h0);
        check("ch0_full", {63'h0, full[0]}, 64'h1);
        cyc(2'b01, 2'b01, 32'h2FF, 32'h0);
        check("ch0_full_rw_refused", {63'h0, full[0]}, 64'h0);
        for (int unsigned i = 0; i < 10; i++) cyc(2'b00, 2'b01, 32'h0, 32'h0);
        cyc(2'b01, 2'b01, 32'h2EE, 32'h0);
        for (int unsigned i = 0; i < 5; i++) begin
            check("ch0_cnt5_nonempty", {63'h0, empty[0]}, 64'h0);
            cyc(2'b00, 2'b01, 32'h0, 32'h0);
        end
        check("ch0_cnt5_empty", {63'h0, empty[0]}, 64'h1);
        check("sb_ch0_size", q0.size(), 64'h0);

        // drain and end of stream
        for (int unsigned i = 0; i < 3; i++) cyc(2'b01, 2'b00, 32'h31 + i, 32'h0);
        wopen[0] = 1'b0; wr_ok[0] = 1'b0;
        tick();
        check("drain_empty", {63'h0, empty[0]}, 64'h0);
        cyc(2'b01, 2'b00, 32'hBAD, 32'h0);
        for (int unsigned i = 0; i < 3; i++) cyc(2'b00, 2'b01, 32'h0, 32'h0);
        tick();
        check("eof_set",   {63'h0, eof[0]},   64'h1);
        check("eof_empty", {63'h0, empty[0]}, 64'h1);
        ropen[0] = 1'b0; rd_ok[0] = 1'b0;
        tick();
        check("eof_clear", {63'h0, eof[0]}, 64'h0);

        // quiesce flush
        wopen[0] = 1'b1; ropen[0] = 1'b1;
        tick();
        wr_ok[0] = 1'b1; rd_ok[0] = 1'b1;
        for (int unsigned i = 0; i < 7; i++) cyc(2'b01, 2'b00, 32'h70 + i, 32'h0);
        quiesce = 1'b1;
        #1;
        check("qsc_full_now", {62'h0, full}, 64'h3);
        tick();
        check("qsc_empty", {63'h0, empty[0]}, 64'h1);
        check("qsc_full",  {62'h0, full},     64'h3);
        check("qsc_ovf",   {62'h0, ovf},      64'h0);
        quiesce = 1'b0;
        q0.delete();
        tick();
        check("qsc_release_full", {62'h0, full}, 64'h0);

        // reset mid-stream
        for (int unsigned i = 0; i < 4; i++) cyc(2'b01, 2'b00, 32'h41 + i, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q0.delete();
        check("mrst_empty", {62'h0, empty}, 64'h3);
        check("mrst_full",  {62'h0, full},  64'h0);
        check("mrst_data",  rdata,          64'h0);
        tick();
        cyc(2'b01, 2'b00, 32'h55, 32'h0);
        cyc(2'b00, 2'b01, 32'h0, 32'h0);
        check("mrst_after_empty", {63'h0, empty[0]}, 64'h1);

`ifdef XLB_LOOP_LEVEL_EN
        for (int unsigned i = 0; i < 9; i++) cyc(2'b01, 2'b00, 32'h90 + i, 32'h0);
        check("fill_level_ch0", {59'h0, fill_level[4:0]}, 64'd9);
        check("fill_level_ch1", {59'h0, fill_level[9:5]}, 64'd0);
        for (int unsigned i = 0; i < 9; i++) cyc(2'b00, 2'b01, 32'h0, 32'h0);
        check("fill_level_zero", {59'h0, fill_level[4:0]}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
